// File: rtl/dmem_vga_bridge_if.sv
// Bus bundle between the processor data-memory port, the bridge and the VGA framebuffer.
// The master side drives the processor store and the blanking indication; the slave is the bridge.
interface dmem_vga_bridge_if #(
   parameter int PIX_AW  = 19,
   parameter int COLOR_W = 8,
   parameter int CNT_W   = 4
);
   logic [11:0]        address_dmem;
   logic [31:0]        data;
   logic               wren;
   logic               dmem_wren;
   logic               fb_ready;
   logic               fb_we;
   logic [PIX_AW-1:0]  fb_addr;
   logic [COLOR_W-1:0] fb_data;
   logic [CNT_W-1:0]   fifo_count;
   logic               overflow;

   modport master (
      output address_dmem, data, wren, fb_ready,
      input  dmem_wren, fb_we, fb_addr, fb_data, fifo_count, overflow
   );

   modport slave (
      input  address_dmem, data, wren, fb_ready,
      output dmem_wren, fb_we, fb_addr, fb_data, fifo_count, overflow
   );
endinterface

// File: rtl/dmem_vga_bridge.sv
// Splits processor stores between data memory and an MMIO pixel port; pixel writes are queued
// in a small FIFO and drained to the framebuffer only while the VGA side reports blanking.
module dmem_vga_bridge #(
   parameter int FIFO_DEPTH = 8,
   parameter int PIX_AW     = 19,
   parameter int PIX_MAX    = 307199,
   parameter int COLOR_W    = 8
) (
   input  logic               clock,
   input  logic               reset,
   dmem_vga_bridge_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PIX_AW + COLOR_W;

   logic             in_window;
   logic             set_ptr;
   logic             push;
   logic             clr_ovf;
   logic             full;
   logic             empty;
   logic             pop;
   logic             push_ok;
   logic             drop;

   logic [PIX_AW-1:0]  ptr;
   logic [AW-1:0]      wr_idx;
   logic [AW-1:0]      rd_idx;
   logic [CW-1:0]      count;
   logic               overflow_q;
   logic               fb_we_q;
   logic [PIX_AW-1:0]  fb_addr_q;
   logic [COLOR_W-1:0] fb_data_q;
   logic [EW-1:0]      mem [FIFO_DEPTH];

   assign in_window = (bus.address_dmem[11:8] == 4'hF);
   assign set_ptr   = bus.wren && in_window && (bus.address_dmem[7:0] == 8'h00);
   assign push      = bus.wren && in_window && (bus.address_dmem[7:0] == 8'h01);
   assign clr_ovf   = bus.wren && in_window && (bus.address_dmem[7:0] == 8'h02) && bus.data[0];

   // Pass-through path is purely combinational so it is unaffected by reset.
   assign bus.dmem_wren = bus.wren && !in_window;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign pop     = bus.fb_ready && !empty;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   // When full with a pop, wr_idx equals rd_idx; the old head is read before it is overwritten.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_idx] <= {ptr, bus.data[COLOR_W-1:0]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr        <= '0;
         wr_idx     <= '0;
         rd_idx     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (set_ptr) begin
            ptr <= (bus.data >= 32'(PIX_MAX)) ? '0 : bus.data[PIX_AW-1:0];
         end else if (push) begin
            ptr <= (ptr == PIX_AW'(PIX_MAX)) ? '0 : ptr + 1'b1;
         end
         if (push_ok) begin
            wr_idx <= wr_idx + 1'b1;
         end
         if (pop) begin
            rd_idx <= rd_idx + 1'b1;
         end
         count <= count + CW'(push_ok) - CW'(pop);
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clr_ovf) begin
            overflow_q <= 1'b0;
         end
      end
   end

   // Registered drain stage: an entry popped on this edge is presented for one cycle after it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         fb_we_q <= pop;
         if (pop) begin
            {fb_addr_q, fb_data_q} <= mem[rd_idx];
         end
      end
   end

   assign bus.fb_we      = fb_we_q;
   assign bus.fb_addr    = fb_addr_q;
   assign bus.fb_data    = fb_data_q;
   assign bus.fifo_count = count;
   assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_dmem_vga_bridge.sv
// Scoreboard bench for dmem_vga_bridge: a queue-based reference model predicts framebuffer
// writes, occupancy and overflow; a separate monitor compares them as the DUT presents them.
module tb_dmem_vga_bridge;
   localparam int PIX_MAX = 307199;
   localparam int DEPTH   = 8;

   typedef struct {
      int addr;
      int color;
   } entry_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   bit   started = 1'b0;

   int total = 0;
   int bad   = 0;

   entry_t model_q[$];
   entry_t exp_q[$];
   int     model_ptr = 0;
   bit     model_ovf = 1'b0;

   dmem_vga_bridge_if bus();

   dmem_vga_bridge dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string name, input longint actual, input longint expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour of one clock edge: drain decision first, then the store's effect.
   task automatic model_edge(input logic [11:0] a, input logic [31:0] d, input bit w, input bit r);
      entry_t e;
      if (r && model_q.size() > 0) begin
         exp_q.push_back(model_q.pop_front());
      end
      if (w && a[11:8] == 4'hF) begin
         case (a[7:0])
            8'h00: model_ptr = (d >= 32'(PIX_MAX)) ? 0 : int'(d);
            8'h01: begin
               if (model_q.size() < DEPTH) begin
                  e.addr  = model_ptr;
                  e.color = int'(d[7:0]);
                  model_q.push_back(e);
               end else begin
                  model_ovf = 1'b1;
               end
               model_ptr = (model_ptr == PIX_MAX) ? 0 : model_ptr + 1;
            end
            8'h02: if (d[0]) model_ovf = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic apply_stimulus(input logic [11:0] a, input logic [31:0] d, input bit w, input bit r);
      @(negedge clock);
      bus.address_dmem = a;
      bus.data         = d;
      bus.wren         = w;
      bus.fb_ready     = r;
      #1;
      check_output("dmem_wren", bus.dmem_wren, (w && a[11:8] != 4'hF) ? 1 : 0);
      @(posedge clock);
      model_edge(a, d, w, r);
   endtask

   task automatic idle_cycles(input int n, input bit r);
      for (int i = 0; i < n; i++) apply_stimulus(12'h000, 32'h0, 1'b0, r);
   endtask

   task automatic reset_pulse();
      @(negedge clock);
      #2;
      bus.wren     = 1'b0;
      bus.fb_ready = 1'b0;
      reset        = 1'b1;
      model_q.delete();
      exp_q.delete();
      model_ptr = 0;
      model_ovf = 1'b0;
      #1;
      check_output("rst_fb_we", bus.fb_we, 0);
      check_output("rst_count", bus.fifo_count, 0);
      check_output("rst_overflow", bus.overflow, 0);
      check_output("rst_fb_addr", bus.fb_addr, 0);
      check_output("rst_fb_data", bus.fb_data, 0);
      @(negedge clock);
      #2;
      reset = 1'b0;
   endtask

   // Monitor: compares every presented write and the visible status against the model.
   always @(negedge clock) begin
      if (started && !reset) begin
         if (bus.fb_we) begin
            if (exp_q.size() == 0) begin
               check_output("fb_we_unexpected", 1, 0);
            end else begin
               entry_t e;
               e = exp_q.pop_front();
               check_output("fb_addr", bus.fb_addr, e.addr);
               check_output("fb_data", bus.fb_data, e.color);
            end
         end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            check_output("fb_we_missing", 0, 1);
         end
         check_output("fifo_count", bus.fifo_count, model_q.size());
         check_output("overflow", bus.overflow, model_ovf);
      end
   end

   initial begin
      logic [11:0] a;
      logic [31:0] d;
      bit          w;
      bit          r;
      int          sel;

      bus.address_dmem = 12'h050;
      bus.data         = 32'h0;
      bus.wren         = 1'b1;
      bus.fb_ready     = 1'b0;
      #1;
      check_output("dmem_wren_in_reset", bus.dmem_wren, 1);
      bus.wren = 1'b0;
      @(negedge clock);
      #1;
      check_output("init_fb_we", bus.fb_we, 0);
      check_output("init_fb_addr", bus.fb_addr, 0);
      check_output("init_fb_data", bus.fb_data, 0);
      check_output("init_count", bus.fifo_count, 0);
      check_output("init_overflow", bus.overflow, 0);
      #1;
      reset   = 1'b0;
      started = 1'b1;

      // Plain store outside the window.
      apply_stimulus(12'h050, 32'h0A, 1'b1, 1'b1);
      idle_cycles(2, 1'b1);

      // Set pointer, push one pixel, then let it drain.
      apply_stimulus(12'hF00, 32'd100, 1'b1, 1'b0);
      apply_stimulus(12'hF01, 32'h3C, 1'b1, 1'b0);
      idle_cycles(1, 1'b0);
      idle_cycles(3, 1'b1);

      // Overfill with no blanking, then drain in order.
      apply_stimulus(12'hF00, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) apply_stimulus(12'hF01, 32'(i + 16), 1'b1, 1'b0);
      idle_cycles(11, 1'b1);

      // Full FIFO with a pop and a push on the same edge.
      apply_stimulus(12'hF02, 32'h1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(12'hF01, 32'(i + 64), 1'b1, 1'b0);
      apply_stimulus(12'hF01, 32'hAB, 1'b1, 1'b1);
      idle_cycles(11, 1'b1);

      // Pointer wrap at the last pixel, clamp of out-of-range pointer values, overflow clear.
      apply_stimulus(12'hF00, 32'd307198, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(12'hF01, 32'(i + 200), 1'b1, 1'b1);
      apply_stimulus(12'hF00, 32'd307199, 1'b1, 1'b1);
      apply_stimulus(12'hF01, 32'h11, 1'b1, 1'b1);
      apply_stimulus(12'hF00, 32'hFFFF_FFFF, 1'b1, 1'b1);
      apply_stimulus(12'hF01, 32'h22, 1'b1, 1'b1);
      apply_stimulus(12'hF03, 32'hFF, 1'b1, 1'b1);
      for (int i = 0; i < 9; i++) apply_stimulus(12'hF01, 32'(i), 1'b1, 1'b0);
      apply_stimulus(12'hF02, 32'h1, 1'b1, 1'b0);
      idle_cycles(11, 1'b1);

      // Reset with entries queued and one write in flight.
      apply_stimulus(12'hF00, 32'd500, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) apply_stimulus(12'hF01, 32'(i + 1), 1'b1, 1'b0);
      apply_stimulus(12'h000, 32'h0, 1'b0, 1'b1);
      reset_pulse();
      apply_stimulus(12'hF01, 32'h55, 1'b1, 1'b0);
      idle_cycles(3, 1'b1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         sel = $urandom_range(0, 9);
         w   = ($urandom_range(0, 7) != 0);
         r   = ($urandom_range(0, 9) < 4);
         d   = $urandom;
         case (sel)
            0, 1: a = 12'($urandom_range(0, 12'hEFF));
            2: begin
               a = 12'hF00;
               if ($urandom_range(0, 1) == 1) d = 32'(PIX_MAX - 3 + $urandom_range(0, 5));
            end
            3, 4, 5, 6: a = 12'hF01;
            7: a = 12'hF02;
            8: a = 12'($urandom_range(12'hF03, 12'hFFF));
            default: begin
               a = 12'hF01;
               w = 1'b0;
            end
         endcase
         apply_stimulus(a, d, w, r);
      end
      idle_cycles(12, 1'b1);
      @(negedge clock);
      #1;
      check_output("final_pending_writes", exp_q.size(), 0);
      check_output("final_model_empty", bus.fifo_count, model_q.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
